// File: rtl/fp_add_normalizer_pkg.sv
// Shared constants and stage records for the FP32 add/sub normalizer.
// EXP_W/FRAC_W set the format; MW is the aligned mantissa width
// (hidden bit at MW-1, G/R/S in [2:0]); SE_W is the signed exponent
// width used through normalization and rounding.
package fp_add_normalizer_pkg;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MW      = FRAC_W + 4;
  localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam int DATA_W  = 1 + EXP_W + FRAC_W;
  localparam int LZ_W    = $clog2(MW + 1);
  localparam int SE_W    = EXP_W + 2;

  localparam logic [DATA_W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [DATA_W-2:0] INF_MAG = {{EXP_W{1'b1}}, {FRAC_W{1'b0}}};

  // S1 -> S2: raw magnitude (carry bit at MW), exponent, specials
  typedef struct packed {
    logic [MW:0]        mag;
    logic [EXP_W-1:0]   e;
    logic               sign;
    logic               zsign;     // sign to use if the result is exactly zero
    logic               spec;
    logic [DATA_W-1:0]  spec_val;
  } s1_t;

  // S2 -> S3: normalized mantissa with hidden bit at MW-1
  typedef struct packed {
    logic [MW-1:0]           m;
    logic signed [SE_W-1:0]  e;
    logic                    sign;
    logic                    zero;
    logic                    spec;
    logic [DATA_W-1:0]       spec_val;
  } s2_t;

  // S3 output register
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               ovf;
    logic               unf;
  } res_t;
endpackage

// File: rtl/fp_add_normalizer_if.sv
// Handshake bundle for the normalizer: aligned-operand input beat and
// packed result output beat. slave = the normalizer, master = its driver.
interface fp_add_normalizer_if;
  import fp_add_normalizer_pkg::*;
  logic               in_valid;
  logic               in_ready;
  logic [EXP_W-1:0]   in_e;
  logic               in_sign;
  logic               in_sign_2;
  logic [MW-1:0]      in_m_1;
  logic [MW-1:0]      in_m_2;
  logic               in_nan;
  logic               in_inf_1;
  logic               in_inf_2;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_overflow;
  logic               out_underflow;

  modport slave (
    input  in_valid, in_e, in_sign, in_sign_2, in_m_1, in_m_2, in_nan, in_inf_1, in_inf_2,
    output in_ready,
    output out_valid, out_data, out_overflow, out_underflow,
    input  out_ready
  );

  modport master (
    output in_valid, in_e, in_sign, in_sign_2, in_m_1, in_m_2, in_nan, in_inf_1, in_inf_2,
    input  in_ready,
    input  out_valid, out_data, out_overflow, out_underflow,
    output out_ready
  );
endinterface

// File: rtl/fp_add_normalizer_lz_counter.sv
// Combinational leading-zero counter.
//  val : W-bit input
//  cnt : number of leading zeros (W when val is zero)
module fp_add_normalizer_lz_counter
  import fp_add_normalizer_pkg::*;
#(
  parameter int W  = MW,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  val,
  output logic [CW-1:0] cnt
);
  // Scan LSB->MSB; the highest set bit writes last and wins.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++)
      if (val[i]) cnt = CW'(W - 1 - i);
  end
endmodule

// File: rtl/fp_add_normalizer.sv
// FP32 add/sub back end: magnitude add/sub (S1), normalize (S2),
// round-to-nearest-even + specials + pack (S3). Valid/ready pipeline,
// full throughput, 3-cycle latency, subnormal results flush to zero.
//  clk  : clock, rising edge
//  rst  : asynchronous reset, active high
//  bus  : operand input beat / packed result output beat (slave side)
module fp_add_normalizer
  import fp_add_normalizer_pkg::*;
(
  input logic            clk,
  input logic            rst,
  fp_add_normalizer_if.slave bus
);
  localparam logic signed [SE_W-1:0] ONE_S  = SE_W'(1);
  localparam logic signed [SE_W-1:0] EMAX_S = SE_W'(EXP_MAX);

  logic [3:1] vld_pipe, ld;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  res_t s3_d, s3_q;

  // Handshake: a stage loads when empty or when its successor loads.
  assign ld[3] = ~vld_pipe[3] | bus.out_ready;
  assign ld[2] = ~vld_pipe[2] | ld[3];
  assign ld[1] = ~vld_pipe[1] | ld[2];
  assign bus.in_ready = ld[1];

  // ---------------- S1: magnitude add / subtract ----------------
  logic sub, m1_ge;
  assign sub   = bus.in_sign ^ bus.in_sign_2;
  assign m1_ge = bus.in_m_1 >= bus.in_m_2;

  always_comb begin
    s1_d       = '0;
    s1_d.e     = bus.in_e;
    s1_d.zsign = bus.in_sign & bus.in_sign_2 & ~sub;
    if (!sub) begin
      s1_d.mag  = {1'b0, bus.in_m_1} + {1'b0, bus.in_m_2};
      s1_d.sign = bus.in_sign;
    end else if (m1_ge) begin
      s1_d.mag  = {1'b0, bus.in_m_1 - bus.in_m_2};
      s1_d.sign = bus.in_sign;
    end else begin
      s1_d.mag  = {1'b0, bus.in_m_2 - bus.in_m_1};
      s1_d.sign = bus.in_sign_2;
    end
    // Special result resolved up front and carried with the beat.
    s1_d.spec = bus.in_nan | bus.in_inf_1 | bus.in_inf_2;
    if (bus.in_nan || (bus.in_inf_1 && bus.in_inf_2 && sub)) s1_d.spec_val = QNAN;
    else if (bus.in_inf_1)                                   s1_d.spec_val = {bus.in_sign, INF_MAG};
    else if (bus.in_inf_2)                                   s1_d.spec_val = {bus.in_sign_2, INF_MAG};
  end

  // ---------------- S2: normalize ----------------
  logic [LZ_W-1:0] lzc;

  fp_add_normalizer_lz_counter #(.W(MW), .CW(LZ_W)) u_lzc (
    .val (s1_q.mag[MW-1:0]),
    .cnt (lzc)
  );

  always_comb begin
    s2_d          = '0;
    s2_d.spec     = s1_q.spec;
    s2_d.spec_val = s1_q.spec_val;
    s2_d.zero     = (s1_q.mag == '0);
    s2_d.sign     = s2_d.zero ? s1_q.zsign : s1_q.sign;
    if (s1_q.mag[MW]) begin
      // Carry out: drop one bit right, keep it sticky.
      s2_d.m = {s1_q.mag[MW:2], s1_q.mag[1] | s1_q.mag[0]};
      s2_d.e = $signed({2'b00, s1_q.e}) + ONE_S;
    end else begin
      s2_d.m = s1_q.mag[MW-1:0] << lzc;
      s2_d.e = $signed({2'b00, s1_q.e}) - $signed({{(SE_W-LZ_W){1'b0}}, lzc});
    end
  end

  // ---------------- S3: round RNE, range check, pack ----------------
  logic [FRAC_W-1:0]       frac, frac_r;
  logic                    up, rc;
  logic signed [SE_W-1:0]  e3;

  always_comb begin
    frac        = s2_q.m[MW-2:3];
    up          = s2_q.m[2] & (s2_q.m[1] | s2_q.m[0] | s2_q.m[3]);
    {rc, frac_r} = {1'b0, frac} + {{FRAC_W{1'b0}}, up};
    // A rounding carry leaves frac_r at zero and bumps the exponent.
    e3          = s2_q.e + $signed({{(SE_W-1){1'b0}}, rc});
    s3_d        = '0;
    if (s2_q.spec) begin
      s3_d.data = s2_q.spec_val;
    end else if (s2_q.zero) begin
      s3_d.data = {s2_q.sign, {(DATA_W-1){1'b0}}};
    end else if (e3 >= EMAX_S) begin
      s3_d.data = {s2_q.sign, INF_MAG};
      s3_d.ovf  = 1'b1;
    end else if (e3 < ONE_S) begin
      s3_d.data = {s2_q.sign, {(DATA_W-1){1'b0}}};
      s3_d.unf  = 1'b1;
    end else begin
      s3_d.data = {s2_q.sign, e3[EXP_W-1:0], frac_r};
    end
  end

  // ---------------- stage registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
    end else begin
      if (ld[1]) vld_pipe[1] <= bus.in_valid;
      if (ld[2]) vld_pipe[2] <= vld_pipe[1];
      if (ld[3]) vld_pipe[3] <= vld_pipe[2];
      if (ld[1] && bus.in_valid)  s1_q <= s1_d;
      if (ld[2] && vld_pipe[1])   s2_q <= s2_d;
      if (ld[3] && vld_pipe[2])   s3_q <= s3_d;
    end
  end

  assign bus.out_valid     = vld_pipe[3];
  assign bus.out_data      = s3_q.data;
  assign bus.out_overflow  = s3_q.ovf;
  assign bus.out_underflow = s3_q.unf;
endmodule

// File: tb/tb_fp_add_normalizer.sv
module tb_fp_add_normalizer;
  logic clk, rst;
  fp_add_normalizer_if bus();

  fp_add_normalizer dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  logic [33:0] exp_q[$];   // {overflow, underflow, data}
  logic [33:0] pend;
  bit last_acc;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: exact integer sum of the aligned mantissas, then RNE on the
  // full remainder below the 24-bit significand.
  function automatic logic [33:0] ref_model(int e, bit sa, bit sb, longint m1, longint m2,
                                            bit nan, bit i1, bit i2);
    bit sub, sign;
    longint x, q, rem, half;
    int p, sh, eb;
    logic [31:0] qb, ebb;
    sub = sa ^ sb;
    if (nan || (i1 && i2 && sub)) return {2'b00, 32'h7FC00000};
    if (i1) return {2'b00, sa, 8'hFF, 23'h0};
    if (i2) return {2'b00, sb, 8'hFF, 23'h0};
    if (!sub)          begin x = m1 + m2; sign = sa; end
    else if (m1 >= m2) begin x = m1 - m2; sign = sa; end
    else               begin x = m2 - m1; sign = sb; end
    if (x == 0) return {2'b00, (!sub && sa && sb), 31'h0};
    p = 0;
    for (int i = 0; i < 40; i++) if (((x >> i) & 1) != 0) p = i;
    if (p > 23) begin
      sh   = p - 23;
      q    = x >> sh;
      rem  = x & ((64'sd1 << sh) - 1);
      half = 64'sd1 << (sh - 1);
      if (rem > half || (rem == half && (q & 1) != 0)) q++;
      if (q == (64'sd1 << 24)) begin q = q >> 1; p++; end
    end else q = x << (23 - p);
    eb = e + p - 26;
    if (eb >= 255) return {2'b10, sign, 8'hFF, 23'h0};
    if (eb <= 0)   return {2'b01, sign, 31'h0};
    qb  = 32'(q);
    ebb = 32'(eb);
    return {2'b00, sign, ebb[7:0], qb[22:0]};
  endfunction

  // Samples on the falling edge, returns #1 after the next rising edge.
  task automatic tick();
    @(negedge clk);
    last_acc = bus.in_valid && bus.in_ready;
    if (last_acc) exp_q.push_back(pend);
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("result", {bus.out_overflow, bus.out_underflow, bus.out_data}, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [7:0] e, bit sa, bit sb, logic [26:0] m1, logic [26:0] m2,
                       bit nan, bit i1, bit i2, logic [33:0] expv);
    bus.in_valid = 1'b1; bus.in_e = e; bus.in_sign = sa; bus.in_sign_2 = sb;
    bus.in_m_1 = m1; bus.in_m_2 = m2; bus.in_nan = nan; bus.in_inf_1 = i1; bus.in_inf_2 = i2;
    pend = expv;
  endtask

  task automatic drive_rand();
    logic [7:0] e; logic [26:0] m1, m2; logic [25:0] r26; bit sa, sb, nan, i1, i2; int r, sh;
    r = $urandom % 10;
    e = (r == 0) ? 8'($urandom_range(1, 30)) : (r == 1) ? 8'($urandom_range(240, 254))
                                                        : 8'($urandom_range(1, 254));
    r26 = 26'($urandom);
    m1  = ($urandom % 10 == 0) ? 27'($urandom) : {1'b1, r26};
    r26 = 26'($urandom);
    sh  = ($urandom % 4 == 0) ? $urandom_range(0, 27) : $urandom_range(0, 3);
    m2  = {1'b1, r26} >> sh;
    sa = 1'($urandom); sb = 1'($urandom);
    nan = ($urandom % 30 == 0); i1 = ($urandom % 20 == 0); i2 = ($urandom % 20 == 0);
    drive(e, sa, sb, m1, m2, nan, i1, i2, ref_model(int'(e), sa, sb, longint'(m1), longint'(m2), nan, i1, i2));
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin tick(); n++; end while (!last_acc && n < 50);
    if (!last_acc) chk("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 100) begin tick(); n++; end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic latency_3p2(string tag);
    int lat;
    drive(8'h80, 0, 0, 27'h6000000, 27'h4000000, 0, 0, 0, {2'b00, 32'h40A00000});
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin tick(); lat++; end
    chk(tag, lat, 3);
    drain();
  endtask

  logic [31:0] held;

  initial begin
    rst = 1'b1; bus.out_ready = 1'b1;
    drive(8'h0, 0, 0, 27'h0, 27'h0, 0, 0, 0, 34'h0);
    bus.in_valid = 1'b0;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_flags", {bus.out_overflow, bus.out_underflow}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", bus.in_ready, 1);

    latency_3p2("latency_3p2");

    // Directed vectors with hand-derived results
    drive(8'h7F, 0, 1, 27'h4000000, 27'h3FFFFFC, 0, 0, 0, {2'b00, 32'h33800000}); wait_accept();
    drive(8'h7F, 0, 0, 27'h4000000, 27'h0000004, 0, 0, 0, {2'b00, 32'h3F800000}); wait_accept();
    drive(8'h7F, 0, 0, 27'h4000008, 27'h0000004, 0, 0, 0, {2'b00, 32'h3F800002}); wait_accept();
    drive(8'hFE, 0, 0, 27'h7FFFFF8, 27'h7FFFFF8, 0, 0, 0, {2'b10, 32'h7F800000}); wait_accept();
    drive(8'hFE, 1, 1, 27'h7FFFFF8, 27'h7FFFFF8, 0, 0, 0, {2'b10, 32'hFF800000}); wait_accept();
    drive(8'h80, 0, 1, 27'h4000000, 27'h0000000, 0, 1, 1, {2'b00, 32'h7FC00000}); wait_accept();
    drive(8'h80, 0, 0, 27'h4000000, 27'h0000000, 0, 1, 1, {2'b00, 32'h7F800000}); wait_accept();
    drive(8'h80, 1, 0, 27'h4000000, 27'h0000000, 0, 0, 1, {2'b00, 32'h7F800000}); wait_accept();
    drive(8'h80, 0, 0, 27'h4000000, 27'h0000000, 1, 0, 0, {2'b00, 32'h7FC00000}); wait_accept();
    drive(8'h01, 0, 1, 27'h4000000, 27'h2000000, 0, 0, 0, {2'b01, 32'h00000000}); wait_accept();
    drive(8'h01, 1, 0, 27'h4000000, 27'h2000000, 0, 0, 0, {2'b01, 32'h80000000}); wait_accept();
    drive(8'h90, 0, 1, 27'h5000000, 27'h5000000, 0, 0, 0, {2'b00, 32'h00000000}); wait_accept();
    drive(8'h90, 1, 1, 27'h0000000, 27'h0000000, 0, 0, 0, {2'b00, 32'h80000000}); wait_accept();
    drive(8'h7F, 0, 0, 27'h7FFFFFC, 27'h0000004, 0, 0, 0, {2'b00, 32'h40000000}); wait_accept();
    drain();

    // Backpressure: 5 beats, consumer stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive_rand(); wait_accept(); end
    chk("bp_in_ready_low", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    held = bus.out_data;
    drive_rand();
    for (int i = 0; i < 4; i++) tick();
    chk("bp_no_accept", exp_q.size(), 3);
    chk("bp_data_stable", bus.out_data, held);
    bus.out_ready = 1'b1;
    wait_accept();
    drive_rand(); wait_accept();
    drain();

    // Asynchronous reset with all stages full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive_rand(); wait_accept(); end
    chk("pre_rst_full", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_data", bus.out_data, 0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    latency_3p2("post_rst_latency");

    // Randomized traffic with random backpressure
    last_acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!(bus.in_valid && !last_acc)) begin
        if ($urandom % 10 < 7) drive_rand();
        else bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom % 10 < 7);
      tick();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
